// File: rtl/key_mode_select_pkg.sv
// Shared definitions for the pushbutton mode selector: debounce FSM states,
// mode width and the default debounce length (20 ms at 50 MHz).
package key_mode_select_pkg;

    localparam int MODE_W = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } debounce_state_t;

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer followed by a four-state debounce FSM.
// Emits a single press event when a low level has been stable long enough.
module key_debounce
    import key_mode_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_event
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync;
    logic             key_low;
    debounce_state_t  state;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to the released level so reset release cannot look like a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign key_low = ~sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RELEASED;
            cnt     <= '0;
            pressed <= 1'b0;
        end else begin
            case (state)
                RELEASED: begin
                    if (key_low) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!key_low) begin
                        state <= RELEASED;
                    end else if (cnt == CNT_LAST) begin
                        state   <= HELD;
                        pressed <= 1'b1;
                        cnt     <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!key_low) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (key_low) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state   <= RELEASED;
                        pressed <= 1'b0;
                        cnt     <= '0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= RELEASED;
                    pressed <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

    // Decoded on the same edge the FSM enters HELD so the mode register updates with it
    assign press_event = (state == PRESS_WAIT) && key_low && (cnt == CNT_LAST);

endmodule

// File: rtl/key_mode_select.sv
// Mode selector driven by two pushbuttons: KEY[0] steps up, KEY[1] steps down,
// wrapping within NUM_MODES; simultaneous presses cancel.
module key_mode_select
    import key_mode_select_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NUM_MODES       = 4
) (
    input  logic              MAX10_CLK1_50,
    input  logic              reset,
    input  logic [1:0]        KEY,
    output logic [MODE_W-1:0] mode,
    output logic              mode_pulse,
    output logic [1:0]        pressed
);

    localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

    logic [1:0] press_event;

    if (NUM_MODES < 2 || NUM_MODES > 4) begin : g_bad_num_modes
        $error("NUM_MODES must be in the range 2..4");
    end

    for (genvar i = 0; i < 2; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk        (MAX10_CLK1_50),
            .reset      (reset),
            .key_n      (KEY[i]),
            .pressed    (pressed[i]),
            .press_event(press_event[i])
        );
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
        if (reset) begin
            mode       <= '0;
            mode_pulse <= 1'b0;
        end else begin
            mode_pulse <= 1'b0;
            case (press_event)
                2'b01: begin
                    mode       <= (mode == LAST_MODE) ? '0 : mode + MODE_W'(1);
                    mode_pulse <= 1'b1;
                end
                2'b10: begin
                    mode       <= (mode == '0) ? LAST_MODE : mode - MODE_W'(1);
                    mode_pulse <= 1'b1;
                end
                default: begin
                    mode <= mode;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_mode_select.sv
// Scoreboard bench for key_mode_select with a short debounce: stimulus queues
// expected mode pulses, a negedge monitor pops and compares them.
module tb_key_mode_select;

    localparam int DEB = 4;
    localparam int NM  = 4;

    typedef struct {
        int         edge_no;
        logic [1:0] mode;
    } expect_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] key;
    logic [1:0] mode;
    logic       mode_pulse;
    logic [1:0] pressed;

    int         cycle = 0;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] model_mode;
    expect_t    exp_q[$];

    key_mode_select #(
        .DEBOUNCE_CYCLES(DEB),
        .NUM_MODES      (NM)
    ) dut (
        .MAX10_CLK1_50(clk),
        .reset        (reset),
        .KEY          (key),
        .mode         (mode),
        .mode_pulse   (mode_pulse),
        .pressed      (pressed)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cycle);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] k, input int n);
        key = k;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_expect(input int edge_no);
        expect_t e;
        e.edge_no = edge_no;
        e.mode    = model_mode;
        exp_q.push_back(e);
    endtask

    task automatic step_model(input int idx);
        if (idx == 0) model_mode = 2'((int'(model_mode) + 1) % NM);
        else          model_mode = 2'((int'(model_mode) + NM - 1) % NM);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        key   = 2'b11;
        model_mode = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_mode", mode, 0);
        checkOutput("reset_pulse", mode_pulse, 0);
        checkOutput("reset_pressed", pressed, 0);
        reset = 1'b0;
        applyStimulus(2'b11, 4);
    endtask

    // Clean press: low long enough to debounce, then a full release
    task automatic press_key(input int idx);
        step_model(idx);
        push_expect(cycle + DEB + 3);
        applyStimulus((idx == 0) ? 2'b10 : 2'b01, 12);
        applyStimulus(2'b11, 12);
        checkOutput("mode_after_press", mode, model_mode);
    endtask

    always @(negedge clk) begin
        if (mode_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: got 1, expected 0 (cycle %0d mode %0d)", cycle, mode);
            end else begin
                expect_t e;
                e = exp_q.pop_front();
                checkOutput("pulse_edge", cycle, e.edge_no);
                checkOutput("pulse_mode", mode, e.mode);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        reset = 1'b1;
        key   = 2'b11;
        model_mode = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("por_mode", mode, 0);
        checkOutput("por_pulse", mode_pulse, 0);
        checkOutput("por_pressed", pressed, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("idle_outputs", {mode, mode_pulse, pressed}, 0);
        end

        // single press: pulse and pressed[0] both appear at edge 7
        step_model(0);
        push_expect(cycle + 7);
        key = 2'b10;
        repeat (6) @(negedge clk);
        checkOutput("pressed_edge6", pressed, 0);
        @(negedge clk);
        checkOutput("pressed_edge7", pressed, 1);
        repeat (5) @(negedge clk);
        applyStimulus(2'b11, 12);
        checkOutput("pressed_released", pressed, 0);
        checkOutput("mode_single", mode, 1);

        // bounce 2 low / 1 high, then a stable low: one event at edge 10
        do_reset();
        step_model(0);
        push_expect(cycle + 10);
        applyStimulus(2'b10, 2);
        applyStimulus(2'b11, 1);
        applyStimulus(2'b10, 12);
        applyStimulus(2'b11, 12);
        checkOutput("mode_bounce", mode, 1);

        // wrap upward through all modes, then wrap downward from 0
        do_reset();
        for (int i = 0; i < 4; i++) press_key(0);
        checkOutput("mode_wrap_up", mode, 0);
        press_key(1);
        checkOutput("mode_wrap_down", mode, 3);

        // simultaneous presses cancel
        applyStimulus(2'b00, 12);
        checkOutput("both_pressed", pressed, 3);
        checkOutput("both_mode", mode, 3);
        applyStimulus(2'b11, 12);
        checkOutput("both_released", pressed, 0);

        // reset interrupts a press; key stays low through and after reset
        do_reset();
        start = cycle;
        key = 2'b10;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_mode", mode, 0);
        checkOutput("midreset_pressed", pressed, 0);
        @(negedge clk);
        reset = 1'b0;
        step_model(0);
        push_expect(start + 11);
        applyStimulus(2'b10, 12);
        applyStimulus(2'b11, 12);
        checkOutput("mode_after_midreset", mode, 1);

        checkOutput("pending_pulses", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
